tl45_memory: RTL and testbench
==============================

Name: tl45_memory

Overview:
- Pipeline stage directly downstream of the TL45 ALU stage. It consumes the ALU's destination register, result value, opcode and store data.
- Memory opcodes (LW/SW/LB/LBU/SB) use the ALU result as a byte address and run a single pipelined-Wishbone transaction. All other opcodes pass through in one registered cycle.
- Produces the writeback buffer (o_dr/o_value), operand-forward outputs and the upstream stall.

Parameters:
- OP_LB, 5'h10, load byte sign-extended
- OP_LBU, 5'h11, load byte zero-extended
- OP_SB, 5'h12, store byte
- OP_LW, 5'h14, load word
- OP_SW, 5'h15, store word

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_pipe_stall  in  1  downstream stall
- o_pipe_stall  out  1  stall to ALU stage
- i_opcode  in  5  opcode of buffered instruction
- i_dr  in  4  destination register (0 = no write)
- i_value  in  32  ALU result / memory byte address
- i_sr_val  in  32  store data
- o_dr  out  4  writeback register
- o_value  out  32  writeback value
- o_of_reg  out  4  forward register (combinational)
- o_of_val  out  32  forward value (combinational)
- o_mem_err  out  1  one-cycle error pulse
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  bus controls
- o_wb_addr  out  30  word address = i_value[31:2]
- o_wb_data  out  32  write data
- o_wb_sel  out  4  byte lanes
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each  bus responses
- i_wb_data  in  32  read data

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; o_dr=0, o_value=0, o_mem_err=0, all o_wb_* =0. If reset lands mid-transaction, cyc/stb drop immediately and the transaction is abandoned.
- States and transitions:
  - IDLE: a memory op with i_pipe_stall=0 and a legal address → REQ (cyc=stb=1 registered).
  - REQ: stb held until i_wb_stall=0 at an edge, then stb→0 and state → WAIT.
  - WAIT: cyc held until ack or err.
  - ack/err while i_pipe_stall=1 → HOLD. Result is latched internally and cyc drops.
  - HOLD: when i_pipe_stall=0, the latched result is written to o_dr/o_value → IDLE.
  - ack arriving in REQ on the same edge stb is accepted counts as completion.
- Bus lanes and data (little-endian):
  - Word: sel=4'hF, o_wb_data=i_sr_val.
  - Byte: sel=1<<i_value[1:0], o_wb_data={4{i_sr_val[7:0]}}.
  - LB sign-extends the selected lane; LBU zero-extends it.
  - we=1 for SW/SB.
- Completion:
  - Loads: o_dr<=i_dr, o_value<=load data.
  - Stores: o_dr<=0, o_value<=0.
  - Latency: a load writes back at the edge of its ack, i.e. at least 2 cycles after issue.
- Error:
  - i_wb_err: cyc drops, o_dr<=0, o_value<=0, o_mem_err=1 for one cycle.
  - Misaligned LW/SW (i_value[1:0]!=0): no bus cycle; the op completes in one cycle as an error (o_dr=0, o_mem_err pulse).
- Non-memory ops: when i_pipe_stall=0, o_dr<=i_dr and o_value<=i_value at the next edge. When i_pipe_stall=1, outputs hold.
- o_pipe_stall = i_pipe_stall OR (memory op AND NOT completing this cycle). It is low in the ack/err cycle (and in HOLD once i_pipe_stall=0), so the ALU advances on that edge. This prevents the same op from re-issuing.
- Forwarding:
  - Non-memory op: o_of_reg=i_dr, o_of_val=i_value.
  - Load: i_dr / load data only in the ack cycle with i_wb_err=0; else 0/0.
  - Store or NOP: 0/0.
- i_wb_err and i_wb_ack together: err wins.
- No new transaction is issued while i_pipe_stall=1.

Test Plan:
- Reset mid-transaction: LW addr 0x100, drop i_reset_n while in WAIT → cyc=0 the same cycle; o_dr=0, o_value=0; no writeback after release.
- Passthrough: ADD, i_dr=3, i_value=0x1234 → next edge o_dr=3, o_value=0x1234, o_pipe_stall=0, no cyc.
- Load word with stall: LW i_dr=5, i_value=0x40, i_wb_stall=1 for 2 cycles, ack+data 0xDEADBEEF one cycle later →
  - o_wb_addr=0x10, sel=F, stb high 3 cycles;
  - o_pipe_stall high until the ack cycle;
  - o_of_reg=5, o_of_val=0xDEADBEEF in the ack cycle;
  - o_dr=5, o_value=0xDEADBEEF after it.
- Byte ops:
  - LB at 0x43 with data 0x80xxxxxx → sel=4'b1000, o_value=0xFFFFFF80.
  - LBU at the same address → o_value=0x00000080.
  - SB 0x5A at 0x41 → sel=4'b0010, we=1, o_wb_data=0x5A5A5A5A, o_dr=0.
- Errors:
  - LW at 0x42 → no cyc, o_mem_err one pulse, o_dr=0.
  - LW at 0x44 answered with i_wb_err → cyc drops, o_mem_err pulse, o_dr=0.
- Downstream stall: LW completes (ack) while i_pipe_stall=1 → state HOLD, o_dr unchanged; on i_pipe_stall→0, next edge o_dr/o_value equal the loaded data and state returns to IDLE.

Source files
------------

// File: rtl/tl45_memory.sv
// TL45 memory stage: passes ALU results through in one registered cycle and
// runs a single pipelined-Wishbone transaction for LW/SW/LB/LBU/SB.
// Handshake: the upstream ALU stage holds its outputs while o_pipe_stall=1 and
// advances on an edge where o_pipe_stall=0; the bus accepts a request on an
// edge where stb=1 and i_wb_stall=0, and completes it with ack or err (err wins).
module tl45_memory #(
   parameter logic [4:0] OP_LB  = 5'h10,
   parameter logic [4:0] OP_LBU = 5'h11,
   parameter logic [4:0] OP_SB  = 5'h12,
   parameter logic [4:0] OP_LW  = 5'h14,
   parameter logic [4:0] OP_SW  = 5'h15
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_pipe_stall,
   output logic        o_pipe_stall,
   input  logic [4:0]  i_opcode,
   input  logic [3:0]  i_dr,
   input  logic [31:0] i_value,
   input  logic [31:0] i_sr_val,
   output logic [3:0]  o_dr,
   output logic [31:0] o_value,
   output logic [3:0]  o_of_reg,
   output logic [31:0] o_of_val,
   output logic        o_mem_err,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [29:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   output logic [3:0]  o_wb_sel,
   input  logic        i_wb_stall,
   input  logic        i_wb_ack,
   input  logic        i_wb_err,
   input  logic [31:0] i_wb_data,
   output logic [1:0]  o_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state;
   logic        is_mem, is_load, is_store, is_word, misaligned;
   logic        bus_done, completing;
   logic [7:0]  ld_byte;
   logic [31:0] ld_data;
   logic [3:0]  res_dr;
   logic [31:0] res_val;
   logic [3:0]  hold_dr;
   logic [31:0] hold_val;
   logic        hold_err;

   assign o_state = state;

   // Opcode decode, load-lane extraction and completion detection
   always_comb begin
      is_load    = (i_opcode == OP_LB) || (i_opcode == OP_LBU) || (i_opcode == OP_LW);
      is_store   = (i_opcode == OP_SB) || (i_opcode == OP_SW);
      is_mem     = is_load || is_store;
      is_word    = (i_opcode == OP_LW) || (i_opcode == OP_SW);
      misaligned = is_word && (i_value[1:0] != 2'b00);

      ld_byte = i_wb_data[7:0];
      case (i_value[1:0])
         2'd0: ld_byte = i_wb_data[7:0];
         2'd1: ld_byte = i_wb_data[15:8];
         2'd2: ld_byte = i_wb_data[23:16];
         2'd3: ld_byte = i_wb_data[31:24];
         default: ld_byte = i_wb_data[7:0];
      endcase
      if (i_opcode == OP_LW)
         ld_data = i_wb_data;
      else if (i_opcode == OP_LB)
         ld_data = {{24{ld_byte[7]}}, ld_byte};
      else
         ld_data = {24'h0, ld_byte};

      // An ack on the same edge the request is accepted also completes it
      bus_done = (i_wb_ack || i_wb_err) &&
                 ((state == S_WAIT) || ((state == S_REQ) && !i_wb_stall));

      // Only a successful load produces a register write
      res_dr  = (is_load && !i_wb_err) ? i_dr : 4'd0;
      res_val = (is_load && !i_wb_err) ? ld_data : 32'd0;

      completing = bus_done || (state == S_HOLD) ||
                   ((state == S_IDLE) && misaligned);
   end

   // Upstream stall and operand forwarding
   always_comb begin
      o_pipe_stall = i_pipe_stall || (is_mem && !completing);
      o_of_reg = 4'd0;
      o_of_val = 32'd0;
      if (!is_mem) begin
         o_of_reg = i_dr;
         o_of_val = i_value;
      end else if (bus_done && is_load && !i_wb_err) begin
         o_of_reg = i_dr;
         o_of_val = ld_data;
      end
   end

   // Transaction FSM with registered bus controls and writeback buffer
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= S_IDLE;
         o_dr      <= 4'd0;
         o_value   <= 32'd0;
         o_mem_err <= 1'b0;
         o_wb_cyc  <= 1'b0;
         o_wb_stb  <= 1'b0;
         o_wb_we   <= 1'b0;
         o_wb_addr <= 30'd0;
         o_wb_data <= 32'd0;
         o_wb_sel  <= 4'd0;
         hold_dr   <= 4'd0;
         hold_val  <= 32'd0;
         hold_err  <= 1'b0;
      end else begin
         o_mem_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!i_pipe_stall) begin
                  if (!is_mem) begin
                     o_dr    <= i_dr;
                     o_value <= i_value;
                  end else if (misaligned) begin
                     o_dr      <= 4'd0;
                     o_value   <= 32'd0;
                     o_mem_err <= 1'b1;
                  end else begin
                     state     <= S_REQ;
                     o_wb_cyc  <= 1'b1;
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= is_store;
                     o_wb_addr <= i_value[31:2];
                     o_wb_data <= is_word ? i_sr_val : {4{i_sr_val[7:0]}};
                     o_wb_sel  <= is_word ? 4'hF : (4'b0001 << i_value[1:0]);
                  end
               end
            end
            S_REQ, S_WAIT: begin
               if ((state == S_REQ) && !i_wb_stall) begin
                  o_wb_stb <= 1'b0;
                  state    <= S_WAIT;
               end
               if (bus_done) begin
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  if (i_pipe_stall) begin
                     state    <= S_HOLD;
                     hold_dr  <= res_dr;
                     hold_val <= res_val;
                     hold_err <= i_wb_err;
                  end else begin
                     state     <= S_IDLE;
                     o_dr      <= res_dr;
                     o_value   <= res_val;
                     o_mem_err <= i_wb_err;
                  end
               end
            end
            S_HOLD: begin
               if (!i_pipe_stall) begin
                  state     <= S_IDLE;
                  o_dr      <= hold_dr;
                  o_value   <= hold_val;
                  o_mem_err <= hold_err;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tl45_memory.sv
// Directed bench for tl45_memory: inputs change 1ns after a rising edge,
// combinational outputs are checked 1ns later, registered outputs after the next edge.
module tb_tl45_memory;

   localparam logic [4:0] OP_NOP = 5'h00;
   localparam logic [4:0] OP_ADD = 5'h01;
   localparam logic [4:0] OP_LB  = 5'h10;
   localparam logic [4:0] OP_LBU = 5'h11;
   localparam logic [4:0] OP_SB  = 5'h12;
   localparam logic [4:0] OP_LW  = 5'h14;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_pipe_stall;
   logic        o_pipe_stall;
   logic [4:0]  i_opcode;
   logic [3:0]  i_dr;
   logic [31:0] i_value;
   logic [31:0] i_sr_val;
   logic [3:0]  o_dr;
   logic [31:0] o_value;
   logic [3:0]  o_of_reg;
   logic [31:0] o_of_val;
   logic        o_mem_err;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [29:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic [3:0]  o_wb_sel;
   logic        i_wb_stall, i_wb_ack, i_wb_err;
   logic [31:0] i_wb_data;
   logic [1:0]  o_state;

   int n_checks = 0;
   int n_errors = 0;

   tl45_memory dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_pipe_stall(i_pipe_stall), .o_pipe_stall(o_pipe_stall),
      .i_opcode(i_opcode), .i_dr(i_dr), .i_value(i_value), .i_sr_val(i_sr_val),
      .o_dr(o_dr), .o_value(o_value), .o_of_reg(o_of_reg), .o_of_val(o_of_val),
      .o_mem_err(o_mem_err),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
      .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
      .i_wb_data(i_wb_data), .o_state(o_state)
   );

   // clock
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_op(input logic [4:0] op, input logic [3:0] dr,
                         input logic [31:0] val, input logic [31:0] sr);
      i_opcode = op;
      i_dr     = dr;
      i_value  = val;
      i_sr_val = sr;
   endtask

   task automatic nop();
      set_op(OP_NOP, 4'd0, 32'd0, 32'd0);
   endtask

   // one ALU passthrough to leave a known non-zero value in the writeback buffer
   task automatic alu(input logic [3:0] dr, input logic [31:0] val);
      set_op(OP_ADD, dr, val, 32'd0);
      tick();
      nop();
   endtask

   initial begin
      i_reset_n    = 1'b0;
      i_pipe_stall = 1'b0;
      i_wb_stall   = 1'b0;
      i_wb_ack     = 1'b0;
      i_wb_err     = 1'b0;
      i_wb_data    = 32'd0;
      nop();
      repeat (2) @(posedge i_clk);
      #1;
      // reset state
      check("rst_dr", 32'(o_dr), 32'd0);
      check("rst_value", o_value, 32'd0);
      check("rst_cyc", 32'(o_wb_cyc), 32'd0);
      check("rst_stb", 32'(o_wb_stb), 32'd0);
      check("rst_err", 32'(o_mem_err), 32'd0);
      check("rst_state", 32'(o_state), 32'(ST_IDLE));
      i_reset_n = 1'b1;
      tick();

      // passthrough
      set_op(OP_ADD, 4'd3, 32'h1234, 32'd0);
      settle();
      check("pt_pstall", 32'(o_pipe_stall), 32'd0);
      check("pt_of_reg", 32'(o_of_reg), 32'd3);
      check("pt_of_val", o_of_val, 32'h1234);
      tick();
      nop();
      check("pt_dr", 32'(o_dr), 32'd3);
      check("pt_value", o_value, 32'h1234);
      check("pt_cyc", 32'(o_wb_cyc), 32'd0);

      // load word with two bus-stall cycles, ack one cycle after acceptance
      set_op(OP_LW, 4'd5, 32'h40, 32'd0);
      i_wb_stall = 1'b1;
      settle();
      check("lw_pstall_idle", 32'(o_pipe_stall), 32'd1);
      check("lw_of_reg_idle", 32'(o_of_reg), 32'd0);
      tick();
      check("lw_addr", 32'(o_wb_addr), 32'h10);
      check("lw_sel", 32'(o_wb_sel), 32'hF);
      check("lw_we", 32'(o_wb_we), 32'd0);
      check("lw_state_req", 32'(o_state), 32'(ST_REQ));
      for (int c = 0; c < 3; c++) begin
         if (c == 2) i_wb_stall = 1'b0;
         settle();
         check("lw_stb_high", 32'(o_wb_stb), 32'd1);
         check("lw_cyc_high", 32'(o_wb_cyc), 32'd1);
         check("lw_pstall_busy", 32'(o_pipe_stall), 32'd1);
         tick();
      end
      check("lw_state_wait", 32'(o_state), 32'(ST_WAIT));
      i_wb_ack  = 1'b1;
      i_wb_data = 32'hDEADBEEF;
      settle();
      check("lw_stb_low", 32'(o_wb_stb), 32'd0);
      check("lw_pstall_ack", 32'(o_pipe_stall), 32'd0);
      check("lw_of_reg", 32'(o_of_reg), 32'd5);
      check("lw_of_val", o_of_val, 32'hDEADBEEF);
      tick();
      i_wb_ack = 1'b0;
      nop();
      check("lw_dr", 32'(o_dr), 32'd5);
      check("lw_value", o_value, 32'hDEADBEEF);
      check("lw_cyc_done", 32'(o_wb_cyc), 32'd0);
      check("lw_state_idle", 32'(o_state), 32'(ST_IDLE));

      // LB at 0x43, ack on the same edge the request is accepted
      set_op(OP_LB, 4'd6, 32'h43, 32'd0);
      tick();
      check("lb_sel", 32'(o_wb_sel), 32'h8);
      check("lb_addr", 32'(o_wb_addr), 32'h10);
      i_wb_ack  = 1'b1;
      i_wb_data = 32'h80123456;
      settle();
      check("lb_of_val", o_of_val, 32'hFFFFFF80);
      tick();
      i_wb_ack = 1'b0;
      nop();
      check("lb_dr", 32'(o_dr), 32'd6);
      check("lb_value", o_value, 32'hFFFFFF80);
      check("lb_state", 32'(o_state), 32'(ST_IDLE));

      // LBU at 0x43, ack in WAIT
      set_op(OP_LBU, 4'd8, 32'h43, 32'd0);
      tick();
      tick();
      check("lbu_state_wait", 32'(o_state), 32'(ST_WAIT));
      i_wb_ack = 1'b1;
      tick();
      i_wb_ack = 1'b0;
      nop();
      check("lbu_dr", 32'(o_dr), 32'd8);
      check("lbu_value", o_value, 32'h00000080);

      // SB 0x5A at 0x41
      set_op(OP_SB, 4'd7, 32'h41, 32'h1234565A);
      tick();
      check("sb_sel", 32'(o_wb_sel), 32'h2);
      check("sb_we", 32'(o_wb_we), 32'd1);
      check("sb_data", o_wb_data, 32'h5A5A5A5A);
      i_wb_ack = 1'b1;
      settle();
      check("sb_of_reg", 32'(o_of_reg), 32'd0);
      tick();
      i_wb_ack = 1'b0;
      nop();
      check("sb_dr", 32'(o_dr), 32'd0);
      check("sb_value", o_value, 32'd0);

      // misaligned LW at 0x42: no bus cycle, one error pulse
      alu(4'd2, 32'h22);
      set_op(OP_LW, 4'd9, 32'h42, 32'd0);
      settle();
      check("mis_pstall", 32'(o_pipe_stall), 32'd0);
      tick();
      nop();
      check("mis_cyc", 32'(o_wb_cyc), 32'd0);
      check("mis_err", 32'(o_mem_err), 32'd1);
      check("mis_dr", 32'(o_dr), 32'd0);
      tick();
      check("mis_err_pulse", 32'(o_mem_err), 32'd0);

      // LW at 0x44 answered with err (ack also raised: err wins)
      alu(4'd2, 32'h22);
      set_op(OP_LW, 4'd9, 32'h44, 32'd0);
      tick();
      tick();
      i_wb_err = 1'b1;
      i_wb_ack = 1'b1;
      i_wb_data = 32'h11111111;
      settle();
      check("err_of_reg", 32'(o_of_reg), 32'd0);
      check("err_pstall", 32'(o_pipe_stall), 32'd0);
      tick();
      i_wb_err = 1'b0;
      i_wb_ack = 1'b0;
      nop();
      check("err_cyc", 32'(o_wb_cyc), 32'd0);
      check("err_pulse", 32'(o_mem_err), 32'd1);
      check("err_dr", 32'(o_dr), 32'd0);
      check("err_value", o_value, 32'd0);
      tick();
      check("err_pulse_end", 32'(o_mem_err), 32'd0);

      // load completes under downstream stall -> HOLD
      alu(4'd1, 32'h11);
      set_op(OP_LW, 4'hA, 32'h80, 32'd0);
      tick();
      tick();
      i_wb_ack  = 1'b1;
      i_wb_data = 32'hCAFEF00D;
      i_pipe_stall = 1'b1;
      settle();
      check("hold_pstall", 32'(o_pipe_stall), 32'd1);
      tick();
      i_wb_ack = 1'b0;
      check("hold_state", 32'(o_state), 32'(ST_HOLD));
      check("hold_cyc", 32'(o_wb_cyc), 32'd0);
      check("hold_dr", 32'(o_dr), 32'd1);
      tick();
      check("hold_state2", 32'(o_state), 32'(ST_HOLD));
      check("hold_value", o_value, 32'h11);
      i_pipe_stall = 1'b0;
      settle();
      check("hold_release_pstall", 32'(o_pipe_stall), 32'd0);
      tick();
      nop();
      check("hold_wb_dr", 32'(o_dr), 32'hA);
      check("hold_wb_value", o_value, 32'hCAFEF00D);
      check("hold_idle", 32'(o_state), 32'(ST_IDLE));

      // reset dropped in WAIT
      set_op(OP_LW, 4'd4, 32'h100, 32'd0);
      tick();
      tick();
      check("rmt_state_wait", 32'(o_state), 32'(ST_WAIT));
      check("rmt_cyc_before", 32'(o_wb_cyc), 32'd1);
      check("rmt_addr", 32'(o_wb_addr), 32'h40);
      i_reset_n = 1'b0;
      settle();
      check("rmt_cyc", 32'(o_wb_cyc), 32'd0);
      check("rmt_dr", 32'(o_dr), 32'd0);
      check("rmt_value", o_value, 32'd0);
      check("rmt_state", 32'(o_state), 32'(ST_IDLE));
      nop();
      tick();
      i_reset_n = 1'b1;
      i_wb_ack  = 1'b1;
      tick();
      i_wb_ack = 1'b0;
      tick();
      check("rmt_no_wb_dr", 32'(o_dr), 32'd0);
      check("rmt_no_cyc", 32'(o_wb_cyc), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // watchdog
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
